// File: rtl/issue_scheduler_pkg.sv
// Shared decode definitions for the dual-issue scheduler: opcode constants,
// the canonical NOP, the scheduler state encoding and field-extraction helpers.
package issue_scheduler_pkg;

    localparam logic [6:0]  OP_R = 7'b0110011;
    localparam logic [6:0]  OP_I = 7'b0010011;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    typedef enum logic {
        PAIR  = 1'b0,
        SPLIT = 1'b1
    } sched_state_e;

    function automatic logic [6:0] opcode_of(input logic [31:0] instr);
        return instr[6:0];
    endfunction

    function automatic logic [4:0] rd_of(input logic [31:0] instr);
        return instr[11:7];
    endfunction

    function automatic logic [4:0] rs1_of(input logic [31:0] instr);
        return instr[19:15];
    endfunction

    function automatic logic [4:0] rs2_of(input logic [31:0] instr);
        return instr[24:20];
    endfunction

    // A writer is an ALU instruction (R or I form) with a non-zero destination.
    function automatic logic is_writer(input logic [31:0] instr);
        return ((opcode_of(instr) == OP_R) || (opcode_of(instr) == OP_I)) &&
               (rd_of(instr) != 5'd0);
    endfunction

endpackage

// File: rtl/issue_scheduler_hazard.sv
// Combinational intra-pair dependency check: does B read or overwrite A's rd?
module hazard_detect
    import issue_scheduler_pkg::*;
(
    input  logic [31:0] instr_a,
    input  logic [31:0] instr_b,
    output logic        hazard
);

    logic       a_writer_s;
    logic       b_alu_s;
    logic       raw_rs1_s;
    logic       raw_rs2_s;
    logic       waw_s;
    logic [4:0] rd_a_s;

    // Evaluate RAW on rs1/rs2 and WAW against A's destination register.
    always_comb begin
        rd_a_s     = rd_of(instr_a);
        a_writer_s = is_writer(instr_a);
        b_alu_s    = (opcode_of(instr_b) == OP_R) || (opcode_of(instr_b) == OP_I);
        raw_rs1_s  = b_alu_s && (rs1_of(instr_b) == rd_a_s);
        raw_rs2_s  = (opcode_of(instr_b) == OP_R) && (rs2_of(instr_b) == rd_a_s);
        waw_s      = is_writer(instr_b) && (rd_of(instr_b) == rd_a_s);
        hazard     = a_writer_s && (raw_rs1_s || raw_rs2_s || waw_s);
    end

endmodule

// File: rtl/issue_scheduler.sv
// Dual-issue scheduler: accepts an instruction pair from fetch and issues it to
// decode slots A/B, splitting dependent pairs over two cycles.
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int          CNT_W     = 16,
    parameter logic [31:0] NOP_INSTR = NOP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger,
    input  logic             fetch_valid,
    input  logic [31:0]      fetch_instr_a,
    input  logic [31:0]      fetch_instr_b,
    output logic             fetch_ready,
    output logic             issue_valid_a,
    output logic             issue_valid_b,
    output logic [31:0]      issue_instr_a,
    output logic [31:0]      issue_instr_b,
    output logic [CNT_W-1:0] pair_count,
    output logic [CNT_W-1:0] split_count,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    sched_state_e state_r;
    sched_state_e next_state_s;
    logic [31:0]  hold_r;
    logic [31:0]  hold_s;
    logic         hazard_s;
    logic         accept_s;
    logic         valid_a_s;
    logic         valid_b_s;
    logic [31:0]  instr_a_s;
    logic [31:0]  instr_b_s;
    logic         pair_inc_s;
    logic         split_inc_s;
    logic         stall_inc_s;

    hazard_detect u_hazard (
        .instr_a (fetch_instr_a),
        .instr_b (fetch_instr_b),
        .hazard  (hazard_s)
    );

    // Ready only in PAIR, never while stalled or while reset is applied.
    always_comb begin
        fetch_ready = (state_r == PAIR) && !trigger && !rst;
        accept_s    = fetch_valid && fetch_ready;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= PAIR;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state: a hazardous acceptance splits; an unstalled SPLIT returns to PAIR.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            PAIR: begin
                if (accept_s && hazard_s) begin
                    next_state_s = SPLIT;
                end else begin
                    next_state_s = PAIR;
                end
            end
            SPLIT: begin
                if (!trigger) begin
                    next_state_s = PAIR;
                end else begin
                    next_state_s = SPLIT;
                end
            end
            default: next_state_s = PAIR;
        endcase
    end

    // Output decode: next slot contents, hold-register update and counter events.
    always_comb begin
        valid_a_s   = 1'b0;
        valid_b_s   = 1'b0;
        instr_a_s   = NOP_INSTR;
        instr_b_s   = NOP_INSTR;
        hold_s      = hold_r;
        pair_inc_s  = 1'b0;
        split_inc_s = 1'b0;
        if (accept_s) begin
            if (hazard_s) begin
                valid_a_s   = 1'b1;
                instr_a_s   = fetch_instr_a;
                hold_s      = fetch_instr_b;
                split_inc_s = 1'b1;
            end else begin
                valid_a_s  = 1'b1;
                valid_b_s  = 1'b1;
                instr_a_s  = fetch_instr_a;
                instr_b_s  = fetch_instr_b;
                pair_inc_s = 1'b1;
            end
        end else if ((state_r == SPLIT) && !trigger) begin
            valid_b_s = 1'b1;
            instr_b_s = hold_r;
        end else begin
            valid_a_s = 1'b0;
            valid_b_s = 1'b0;
        end
        stall_inc_s = trigger && (fetch_valid || (state_r == SPLIT));
    end

    // Issue slots and hold register, registered for a one-cycle issue latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_valid_a <= 1'b0;
            issue_valid_b <= 1'b0;
            issue_instr_a <= NOP_INSTR;
            issue_instr_b <= NOP_INSTR;
            hold_r        <= NOP_INSTR;
        end else begin
            issue_valid_a <= valid_a_s;
            issue_valid_b <= valid_b_s;
            issue_instr_a <= instr_a_s;
            issue_instr_b <= instr_b_s;
            hold_r        <= hold_s;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            pair_count  <= {CNT_W{1'b0}};
            split_count <= {CNT_W{1'b0}};
            stall_count <= {CNT_W{1'b0}};
        end else begin
            if (pair_inc_s && (pair_count != CNT_MAX)) begin
                pair_count <= pair_count + CNT_ONE;
            end
            if (split_inc_s && (split_count != CNT_MAX)) begin
                split_count <= split_count + CNT_ONE;
            end
            if (stall_inc_s && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + CNT_ONE;
            end
        end
    end

endmodule

// File: doc/issue_scheduler.md
ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of each performance counter.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h00000013, the instruction placed in an empty issue slot.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port trigger, input, 1, pipeline stall request; no acceptance and no issue while high.
REQ-006 SHALL have port fetch_valid, input, 1, fetch presents a valid instruction pair.
REQ-007 SHALL have port fetch_instr_a, input, 32, program-order-first instruction of the pair.
REQ-008 SHALL have port fetch_instr_b, input, 32, program-order-second instruction of the pair.
REQ-009 SHALL have port fetch_ready, output, 1, scheduler accepts the pair this cycle.
REQ-010 SHALL have ports issue_valid_a and issue_valid_b, output, 1 each, registered slot-valid flags to decode.
REQ-011 SHALL have ports issue_instr_a and issue_instr_b, output, 32 each, registered instructions to decode slots A and B.
REQ-012 SHALL have ports pair_count, split_count and stall_count, output, CNT_W each, performance counters.

Function
REQ-013 SHALL accept a pair on a cycle where fetch_valid and fetch_ready are both high, and only then.
REQ-014 SHALL drive fetch_ready = (state == PAIR) and not trigger.
REQ-015 SHALL have two states: PAIR (ready for a new pair) and SPLIT (holding instruction B).
REQ-016 SHALL mark an instruction as a writer when its opcode is 7'b0110011 (R) or 7'b0010011 (I-ALU) and rd is not 0.
REQ-017 SHALL flag a hazard when A is a writer and any of these holds: B.rs1 == A.rd with B opcode R or I-ALU; B.rs2 == A.rd with B opcode R; B is a writer with B.rd == A.rd.
REQ-018 SHALL, on acceptance without a hazard, load both slots at the next edge: valid_a=valid_b=1, instr_a=A, instr_b=B, and remain in PAIR.
REQ-019 SHALL, on acceptance with a hazard, load slot A only (valid_b=0, instr_b=NOP_INSTR), latch B into a hold register, and move to SPLIT.
REQ-020 SHALL, in SPLIT with trigger low, load slot B with the held instruction (valid_a=0, instr_a=NOP_INSTR, valid_b=1) and return to PAIR; the pair therefore takes two issue cycles.
REQ-021 SHALL, in SPLIT with trigger high, stay in SPLIT with the hold register unchanged.
REQ-022 SHALL, on any cycle with no acceptance and no SPLIT issue, load both slots with valid=0 and NOP_INSTR.
REQ-023 SHALL have an issue latency of exactly one cycle, from the accepting edge to the slots being visible at the outputs.
REQ-024 SHALL increment pair_count on each hazard-free acceptance and split_count on each hazard acceptance.
REQ-025 SHALL increment stall_count on each cycle with trigger high and (fetch_valid high or state == SPLIT).
REQ-026 SHALL make all counters saturate at all-ones; none wraps.
REQ-027 SHALL pass through opcodes other than R and I-ALU unchanged in their slot; they are never writers and never dependents.

Reset
REQ-028 SHALL, while rst is high at a clock edge, set state=PAIR, issue_valid_a=issue_valid_b=0, issue_instr_a=issue_instr_b=NOP_INSTR, hold register=NOP_INSTR, and all counters=0.
REQ-029 SHALL have rst override trigger and any handshake; reset in SPLIT discards the held instruction.
REQ-030 SHALL hold fetch_ready low during the reset cycle.

Structure
REQ-031 SHALL take the OP_R and OP_I opcode constants, the NOP constant and the state enum (PAIR, SPLIT) from the shared decode package.
REQ-032 SHALL implement the hazard check of REQ-016/REQ-017 in one combinational sub-module, hazard_detect.

Verification
REQ-033 SHALL cover: A=add x1,x2,x3 with B=add x4,x5,x6 -> fetch_ready=1; next cycle both slots valid with those instructions; pair_count=1.
REQ-034 SHALL cover: A=addi x5,x0,1 with B=add x6,x5,x7 -> cycle+1: slot A only; cycle+2: slot B only with held B; fetch_ready=0 in SPLIT; split_count=1.
REQ-035 SHALL cover: A=addi x0,x0,5 with B=add x6,x0,x0 -> no hazard because rd=0; pair issued together.
REQ-036 SHALL cover: trigger high 3 cycles while in SPLIT -> held B stays unchanged, slots hold valid=0/NOP, stall_count=3; trigger low -> B issues.
REQ-037 SHALL cover: counter preloaded to all-ones (CNT_W=4, 15) plus another pair -> counter stays 15.
REQ-038 SHALL cover: rst asserted in SPLIT -> next cycle state=PAIR, slots invalid/NOP, counters 0, held B never issues.
